// File: rtl/cci_mpf_csr_event_counters_pkg.sv
// Shared definitions for the MPF CSR event counters: event count, vector type and bit mapping.
// Latency: none (definitions only); backpressure: n/a.
package cci_mpf_csrs_pkg;

  localparam int CCI_MPF_NUM_EVENTS = 11;

  typedef logic [CCI_MPF_NUM_EVENTS-1:0] t_cci_mpf_event_vec;

  localparam int VTP_4KB_HIT      = 0;
  localparam int VTP_4KB_MISS     = 1;
  localparam int VTP_2MB_HIT      = 2;
  localparam int VTP_2MB_MISS     = 3;
  localparam int VTP_PT_WALK_BUSY = 4;
  localparam int VTP_FAILED_XLATE = 5;
  localparam int VC_MAP_CHANGED   = 6;
  localparam int WRO_RR           = 7;
  localparam int WRO_RW           = 8;
  localparam int WRO_WR           = 9;
  localparam int WRO_WW           = 10;

  localparam int RD_DATA_W  = 64;
  localparam int RD_IDX_W   = 4;
  localparam int SAT_BIT    = 63;

endpackage

// File: rtl/cci_mpf_csr_event_counters_if.sv
// Event wires from the MPF shims plus the CSR clear/freeze/read channel.
// Latency: none (wiring only); backpressure: none, reads are accepted every cycle.
interface cci_mpf_csr_event_counters_if;
  import cci_mpf_csrs_pkg::*;

  logic vtp_4kb_hit;
  logic vtp_4kb_miss;
  logic vtp_2mb_hit;
  logic vtp_2mb_miss;
  logic vtp_pt_walk_busy;
  logic vtp_failed_xlate;
  logic vc_map_changed;
  logic wro_rr;
  logic wro_rw;
  logic wro_wr;
  logic wro_ww;

  logic                  freeze;
  logic                  clr_en;
  t_cci_mpf_event_vec    clr_mask;
  logic                  rd_en;
  logic [RD_IDX_W-1:0]   rd_idx;
  logic                  rd_valid;
  logic [RD_DATA_W-1:0]  rd_data;
  t_cci_mpf_event_vec    sat_status;

  // Driven by the shims / CSR manager.
  modport master (
    output vtp_4kb_hit, vtp_4kb_miss, vtp_2mb_hit, vtp_2mb_miss,
           vtp_pt_walk_busy, vtp_failed_xlate, vc_map_changed,
           wro_rr, wro_rw, wro_wr, wro_ww,
           freeze, clr_en, clr_mask, rd_en, rd_idx,
    input  rd_valid, rd_data, sat_status
  );

  // Implemented by the counter block.
  modport slave (
    input  vtp_4kb_hit, vtp_4kb_miss, vtp_2mb_hit, vtp_2mb_miss,
           vtp_pt_walk_busy, vtp_failed_xlate, vc_map_changed,
           wro_rr, wro_rw, wro_wr, wro_ww,
           freeze, clr_en, clr_mask, rd_en, rd_idx,
    output rd_valid, rd_data, sat_status
  );

endinterface

// File: rtl/cci_mpf_sat_counter.sv
// One saturating event counter with a sticky saturated flag; clear beats hold beats increment.
// Latency: count/sat update on the edge after inc/clr; backpressure: none.
module cci_mpf_sat_counter #(
  parameter int COUNTER_WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     inc,
  input  logic                     clr,
  input  logic                     hold,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     sat
);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (clr) begin
      // A same-cycle increment is dropped, not carried into the fresh count.
      count_d = '0;
      sat_d   = 1'b0;
    end else if (hold) begin
      count_d = count_q;
    end else if (inc) begin
      if (&count_q) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/cci_mpf_csr_event_counters.sv
// Stages MPF event pulses, accumulates them in saturating counters and serves indexed CSR reads.
// Latency: event to counter 2 edges, read request to response 1 cycle; backpressure: none.
module cci_mpf_csr_event_counters
  import cci_mpf_csrs_pkg::*;
#(
  parameter int NUM_EVENTS    = CCI_MPF_NUM_EVENTS,
  parameter int COUNTER_WIDTH = 48
) (
  input  logic                          clk,
  input  logic                          reset_n,
  cci_mpf_csr_event_counters_if.slave   csr
);

  t_cci_mpf_event_vec        evt_in;
  t_cci_mpf_event_vec        evt_q;
  t_cci_mpf_event_vec        sat_vec;
  logic [COUNTER_WIDTH-1:0]  cnt [NUM_EVENTS];

  logic                      rd_valid_q;
  logic [RD_DATA_W-1:0]      rd_data_q, rd_data_d;

  always_comb begin
    evt_in                   = '0;
    evt_in[VTP_4KB_HIT]      = csr.vtp_4kb_hit;
    evt_in[VTP_4KB_MISS]     = csr.vtp_4kb_miss;
    evt_in[VTP_2MB_HIT]      = csr.vtp_2mb_hit;
    evt_in[VTP_2MB_MISS]     = csr.vtp_2mb_miss;
    evt_in[VTP_PT_WALK_BUSY] = csr.vtp_pt_walk_busy;
    evt_in[VTP_FAILED_XLATE] = csr.vtp_failed_xlate;
    evt_in[VC_MAP_CHANGED]   = csr.vc_map_changed;
    evt_in[WRO_RR]           = csr.wro_rr;
    evt_in[WRO_RW]           = csr.wro_rw;
    evt_in[WRO_WR]           = csr.wro_wr;
    evt_in[WRO_WW]           = csr.wro_ww;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_in;
    end
  end

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_ctr
    cci_mpf_sat_counter #(
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (evt_q[g]),
      .clr     (csr.clr_en & csr.clr_mask[g]),
      .hold    (csr.freeze),
      .count   (cnt[g]),
      .sat     (sat_vec[g])
    );
  end

  // Read word is built from pre-edge counter state, so a same-cycle clear returns the old value.
  always_comb begin
    rd_data_d = rd_data_q;
    if (csr.rd_en) begin
      rd_data_d = '0;
      if (csr.rd_idx < RD_IDX_W'(NUM_EVENTS)) begin
        rd_data_d[COUNTER_WIDTH-1:0] = cnt[csr.rd_idx];
        rd_data_d[SAT_BIT]           = sat_vec[csr.rd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= csr.rd_en;
      rd_data_q  <= rd_data_d;
    end
  end

  // A response due in the cycle reset asserts is suppressed rather than delivered.
  assign csr.rd_valid   = rd_valid_q & reset_n;
  assign csr.rd_data    = rd_data_q;
  assign csr.sat_status = sat_vec;

endmodule
